// File: rtl/mmio_uart_pkg.sv
// Shared constants and types for the memory-mapped UART bridge.
// Register offsets, STATUS bit positions and the TX state encoding.
package mmio_uart_pkg;

   localparam logic [3:0] UART_TXDATA_OFF = 4'h0;
   localparam logic [3:0] UART_STATUS_OFF = 4'h8;

   localparam int STAT_EMPTY_BIT = 0;
   localparam int STAT_FULL_BIT  = 1;
   localparam int STAT_OVF_BIT   = 2;
   localparam int STAT_BUSY_BIT  = 3;
   localparam int STAT_COUNT_LSB = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } txState_e;

endpackage

// File: rtl/mmio_uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty/count derive from
// the pointer difference. DEPTH must be a power of two, at least 2.
module mmio_uart_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           data_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wrPtr_q, wrPtr_d;
   logic [AW:0]      rdPtr_q, rdPtr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             doPush;
   logic             doPop;

   assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign empty_o = (wrPtr_q == rdPtr_q);
   assign count_o = wrPtr_q - rdPtr_q;
   assign data_o  = mem_q[rdPtr_q[AW-1:0]];

   // Full/empty are judged on the pre-edge pointers, so a push into a full
   // FIFO is refused even if a pop happens in the same cycle.
   assign doPush = push_i && !full_o;
   assign doPop  = pop_i && !empty_o;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (doPush) wrPtr_d = wrPtr_q + (AW+1)'(1);
      if (doPop)  rdPtr_d = rdPtr_q + (AW+1)'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/mmio_uart.sv
// MMIO UART bridge: TXDATA/RXDATA at +0x0, STATUS at +0x8, paced TX output.
// Define MMIO_UART_RX_EN to include the RX request path.
module mmio_uart
   import mmio_uart_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR  = 64'h1000_0000,
   parameter int          FIFO_DEPTH = 8,
   parameter int          CHAR_GAP   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_dmem_en,
   input  logic [63:0] io_dmem_addr,
   input  logic        io_dmem_wen,
   input  logic [63:0] io_dmem_wdata,
   output logic        io_dmem_hit,
   output logic [63:0] io_dmem_rdata,
   output logic        io_uart_out_valid,
   output logic [7:0]  io_uart_out_ch,
   output logic        io_uart_in_valid,
   input  logic [7:0]  io_uart_in_ch
);

   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int GAP_W = (CHAR_GAP > 0) ? $clog2(CHAR_GAP + 1) : 1;

   txState_e         state_q, state_d;
   logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
   logic [7:0]       ch_q, ch_d;
   logic [63:0]      rdata_q, rdata_d;
   logic             overflow_q, overflow_d;

   logic             access;
   logic [3:0]       offset;
   logic             txWrite;
   logic             statWrite;
   logic             fifoPop;
   logic             fifoFull;
   logic             fifoEmpty;
   logic [7:0]       fifoData;
   logic [CW-1:0]    fifoCount;
   logic [63:0]      statusWord;
   logic [63:0]      rxWord;
   logic             unusedWdata;

   assign io_dmem_hit = (io_dmem_addr[63:4] == BASE_ADDR[63:4]);
   assign access      = io_dmem_en && io_dmem_hit;
   assign offset      = io_dmem_addr[3:0];
   assign txWrite     = access && io_dmem_wen && (offset == UART_TXDATA_OFF);
   assign statWrite   = access && io_dmem_wen && (offset == UART_STATUS_OFF);
   assign unusedWdata = ^{io_dmem_wdata[63:8], io_dmem_wdata[1:0], io_dmem_wdata[7:3]};

`ifdef MMIO_UART_RX_EN
   assign io_uart_in_valid = access && !io_dmem_wen && (offset == UART_TXDATA_OFF);
   assign rxWord           = {56'b0, io_uart_in_ch};
`else
   logic unusedRxCh;
   assign io_uart_in_valid = 1'b0;
   assign rxWord           = '0;
   assign unusedRxCh       = ^io_uart_in_ch;
`endif

   mmio_uart_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) txFifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (txWrite),
      .pop_i   (fifoPop),
      .data_i  (io_dmem_wdata[7:0]),
      .data_o  (fifoData),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .count_o (fifoCount)
   );

   always_comb begin
      statusWord                         = '0;
      statusWord[STAT_EMPTY_BIT]         = fifoEmpty;
      statusWord[STAT_FULL_BIT]          = fifoFull;
      statusWord[STAT_OVF_BIT]           = overflow_q;
      statusWord[STAT_BUSY_BIT]          = (state_q != IDLE);
      statusWord[STAT_COUNT_LSB +: 8]    = 8'(fifoCount);
   end

   // Read data is only updated by hit reads and otherwise holds its value.
   always_comb begin
      rdata_d = rdata_q;
      if (access && !io_dmem_wen) begin
         case (offset)
            UART_TXDATA_OFF: rdata_d = rxWord;
            UART_STATUS_OFF: rdata_d = statusWord;
            default:         rdata_d = '0;
         endcase
      end
   end

   // A dropped push and a clear in the same cycle leave overflow set.
   always_comb begin
      overflow_d = overflow_q;
      if (statWrite && io_dmem_wdata[STAT_OVF_BIT]) overflow_d = 1'b0;
      if (txWrite && fifoFull)                      overflow_d = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      gapCnt_d = gapCnt_q;
      ch_d     = ch_q;
      fifoPop  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifoEmpty) begin
               fifoPop = 1'b1;
               ch_d    = fifoData;
               state_d = SEND;
            end
         end
         SEND: begin
            gapCnt_d = '0;
            state_d  = (CHAR_GAP > 0) ? GAP : IDLE;
         end
         GAP: begin
            if (gapCnt_q == GAP_W'(CHAR_GAP - 1)) begin
               gapCnt_d = '0;
               state_d  = IDLE;
            end else begin
               gapCnt_d = gapCnt_q + GAP_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         gapCnt_q   <= '0;
         ch_q       <= '0;
         rdata_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gapCnt_q   <= gapCnt_d;
         ch_q       <= ch_d;
         rdata_q    <= rdata_d;
         overflow_q <= overflow_d;
      end
   end

   assign io_dmem_rdata     = rdata_q;
   assign io_uart_out_valid = (state_q == SEND);
   assign io_uart_out_ch    = ch_q;

endmodule
